// File: rtl/axis_insert_header_param_if.sv
// Bundle for the header inserter: payload in, header in, and re-packed stream out.
// The DUT takes the slave view and the source/sink side takes the master view.
interface axis_insert_header_param_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, ready_out,
           valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_in, valid_out, data_out, keep_out, last_out, ready_insert
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, ready_out,
           valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert
  );
endinterface

// File: rtl/axis_insert_header_param.sv
// Prepends an H-byte header (0..DATA_BYTE_WD) to an AXI-Stream packet, re-packing the
// payload so only the final beat may be partial; an overflowing tail leaves in a flush beat.
module axis_insert_header_param #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
  input logic                       clk,
  input logic                       rst_n,
  axis_insert_header_param_if.slave bus
);

  typedef enum logic [1:0] {INIT, IDLE, STREAM, FLUSH} state_t;

  state_t state, state_nxt;

  logic [BYTE_CNT_WD-1:0]  h_reg, fcnt_reg, fcnt_nxt;
  logic [DATA_WD-1:0]      residue, residue_nxt, hdr_residue;
  logic [DATA_WD-1:0]      beat_data, flush_data;
  logic [DATA_BYTE_WD-1:0] beat_keep, flush_keep;
  logic                    fits;

  logic                    valid_q, last_q;
  logic [DATA_WD-1:0]      data_q;
  logic [DATA_BYTE_WD-1:0] keep_q;

  logic out_free, ready_in_c, ready_insert_c;
  logic acc_hdr, acc_in, load_flush;

  assign out_free   = !valid_q || bus.ready_out;
  assign acc_hdr    = (state == IDLE) && bus.valid_insert;
  assign acc_in     = (state == STREAM) && bus.valid_in && out_free;
  assign load_flush = (state == FLUSH) && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    ready_in_c     = 1'b0;
    ready_insert_c = 1'b0;
    case (state)
      INIT: state_nxt = IDLE;
      IDLE: begin
        ready_insert_c = 1'b1;
        if (bus.valid_insert) state_nxt = STREAM;
      end
      STREAM: begin
        ready_in_c = out_free;
        if (bus.valid_in && out_free && bus.last_in) state_nxt = fits ? IDLE : FLUSH;
      end
      FLUSH: if (out_free) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Byte b counts from the LSB; p is its position from the first byte on the wire.
  // Residue holds the H held-back bytes right-aligned, so its top byte is index H-1.
  always_comb begin
    int unsigned h, hi, f, k, total, p;
    h           = 32'(h_reg);
    hi          = 32'(bus.byte_insert_cnt);
    f           = 32'(fcnt_reg);
    k           = 0;
    beat_data   = '0;
    flush_data  = '0;
    residue_nxt = '0;
    hdr_residue = '0;
    beat_keep   = '0;
    flush_keep  = '0;
    for (int unsigned b = 0; b < DATA_BYTE_WD; b++) k = k + 32'(bus.keep_in[b]);
    total    = h + k;
    fits     = (total <= DATA_BYTE_WD);
    fcnt_nxt = fits ? '0 : BYTE_CNT_WD'(total - DATA_BYTE_WD);
    for (int unsigned b = 0; b < DATA_BYTE_WD; b++) begin
      p             = DATA_BYTE_WD - 1 - b;
      beat_keep[b]  = !bus.last_in || (p < total);
      flush_keep[b] = (p < f);
      if (b < h)  residue_nxt[8*b +: 8] = bus.data_in[8*b +: 8];
      if (b < hi) hdr_residue[8*b +: 8] = bus.data_insert[8*b +: 8];
      for (int unsigned s = 0; s < DATA_BYTE_WD; s++) begin
        if (beat_keep[b] && (p < h) && (s == h - 1 - p))
          beat_data[8*b +: 8] = residue[8*s +: 8];
        if (beat_keep[b] && (p >= h) && (s == b + h))
          beat_data[8*b +: 8] = bus.data_in[8*s +: 8];
        if (flush_keep[b] && (s == h - 1 - p))
          flush_data[8*b +: 8] = residue[8*s +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg    <= '0;
      fcnt_reg <= '0;
      residue  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      keep_q   <= '0;
    end else begin
      if (acc_hdr) begin
        h_reg   <= bus.byte_insert_cnt;
        residue <= hdr_residue;
      end else if (acc_in) begin
        residue <= residue_nxt;
      end
      if (acc_in) fcnt_reg <= fcnt_nxt;

      // A new load may coincide with the downstream taking the current beat.
      if (acc_in) begin
        valid_q <= 1'b1;
        data_q  <= beat_data;
        keep_q  <= beat_keep;
        last_q  <= bus.last_in && fits;
      end else if (load_flush) begin
        valid_q <= 1'b1;
        data_q  <= flush_data;
        keep_q  <= flush_keep;
        last_q  <= 1'b1;
      end else if (bus.ready_out) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.ready_in     = ready_in_c;
  assign bus.ready_insert = ready_insert_c;
  assign bus.valid_out    = valid_q;
  assign bus.data_out     = data_q;
  assign bus.keep_out     = keep_q;
  assign bus.last_out     = last_q;

endmodule

// File: tb/tb_axis_insert_header_param.sv
// Self-checking bench for axis_insert_header_param at 32-bit width: directed vector table,
// byte-queue reference under random backpressure, early payload, and reset corner cases.
module tb_axis_insert_header_param;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_insert_header_param_if #(.DATA_WD(DW)) bus ();
  axis_insert_header_param #(.DATA_WD(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [2:0]       h;
    logic [31:0]      hdr;
    logic [1:0]       nb;
    logic [1:0][31:0] pl;
    logic [3:0]       lk;
    logic [1:0]       ne;
    logic [2:0][31:0] ed;
    logic [2:0][3:0]  ek;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int rmode = 0;  // 0: always ready, 1: random ready, 2: never ready
  beat_t got_q[$];
  beat_t exp_q[$];
  logic [7:0] mb[$];
  vec_t vt[7];
  logic  hold_v;
  beat_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sink: chooses ready_out at +1 and records every beat that will handshake on the next edge.
  initial begin
    bus.ready_out = 1'b0;
    hold_v = 1'b0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          check("stall_hold", {bus.valid_out, bus.data_out, bus.keep_out, bus.last_out}, {1'b1, held});
        case (rmode)
          0:       bus.ready_out = 1'b1;
          1:       bus.ready_out = 1'($urandom_range(0, 1));
          default: bus.ready_out = 1'b0;
        endcase
        held = '{d: bus.data_out, k: bus.keep_out, l: bus.last_out};
        if (bus.valid_out && bus.ready_out) got_q.push_back(held);
        hold_v = bus.valid_out && !bus.ready_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_header(input int h, input logic [31:0] hdr);
    int cyc;
    cyc = 0;
    bus.valid_insert    = 1'b1;
    bus.data_insert     = hdr;
    bus.byte_insert_cnt = 3'(h);
    bus.keep_insert     = 4'((1 << h) - 1);
    while (!bus.ready_insert && cyc < 200) begin tick(); cyc++; end
    if (!bus.ready_insert) check("header_timeout", 64'(cyc), 64'd0);
    tick();
    bus.valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int cyc;
    cyc = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    while (!bus.ready_in && cyc < 500) begin tick(); cyc++; end
    if (!bus.ready_in) check("payload_timeout", 64'(cyc), 64'd0);
    tick();
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 2000) begin tick(); cyc++; end
    repeat (4) tick();
  endtask

  task automatic compare_exp(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic run_vec(input int i);
    got_q.delete();
    exp_q.delete();
    for (int j = 0; j < int'(vt[i].ne); j++)
      exp_q.push_back('{d: vt[i].ed[j], k: vt[i].ek[j], l: (j == int'(vt[i].ne) - 1)});
    send_header(int'(vt[i].h), vt[i].hdr);
    for (int b = 0; b < int'(vt[i].nb); b++) begin
      send_beat(vt[i].pl[b], (b == int'(vt[i].nb) - 1) ? vt[i].lk : 4'hF, b == int'(vt[i].nb) - 1);
      if (b == 0) check($sformatf("vec%0d_latency", i), 64'(bus.valid_out), 64'd1);
    end
    wait_drain(exp_q.size());
    compare_exp($sformatf("vec%0d", i));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.last_in = 1'b0;
    bus.valid_insert = 1'b0;
    #1;
    check({tag, "_outs_zero"}, {bus.valid_out, bus.last_out, bus.ready_in, bus.ready_insert,
                                bus.keep_out, bus.data_out}, '0);
    tick();
    tick();
    rst_n = 1'b1;
    check({tag, "_init_ready_insert"}, 64'(bus.ready_insert), 64'd0);
    tick();
    check({tag, "_idle_ready_insert"}, 64'(bus.ready_insert), 64'd1);
  endtask

  function automatic void build_exp();
    beat_t e;
    int n;
    while (mb.size() > 0) begin
      e = '0;
      n = 0;
      while (n < 4 && mb.size() > 0) begin
        e.d[8*(3-n) +: 8] = mb.pop_front();
        e.k[3-n] = 1'b1;
        n++;
      end
      e.l = (mb.size() == 0);
      exp_q.push_back(e);
    end
  endfunction

  function automatic vec_t mk(input int h, input logic [31:0] hdr, input int nb,
                              input logic [31:0] p0, input logic [31:0] p1, input logic [3:0] lk,
                              input int ne, input logic [31:0] e0, input logic [3:0] k0,
                              input logic [31:0] e1, input logic [3:0] k1,
                              input logic [31:0] e2, input logic [3:0] k2);
    vec_t v;
    v.h = 3'(h); v.hdr = hdr; v.nb = 2'(nb); v.pl[0] = p0; v.pl[1] = p1; v.lk = lk;
    v.ne = 2'(ne); v.ed[0] = e0; v.ek[0] = k0; v.ed[1] = e1; v.ek[1] = k1;
    v.ed[2] = e2; v.ek[2] = k2;
    return v;
  endfunction

  initial begin
    logic [31:0] pdat[64];
    logic [3:0]  pk[64];
    logic [31:0] hdr;
    int          kb;

    vt[0] = mk(3, 32'h00AABBCC, 2, 32'h11223344, 32'h55667788, 4'hF,
               3, 32'hAABBCC11, 4'hF, 32'h22334455, 4'hF, 32'h66778800, 4'hE);
    vt[1] = mk(2, 32'h0000A1A2, 1, 32'h12345678, 32'h0, 4'hC,
               1, 32'hA1A21234, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0);
    vt[2] = mk(0, 32'h0, 2, 32'h01020304, 32'h0A0B0CFF, 4'hE,
               2, 32'h01020304, 4'hF, 32'h0A0B0C00, 4'hE, 32'h0, 4'h0);
    vt[3] = mk(4, 32'hDEADBEEF, 1, 32'h11223344, 32'h0, 4'h8,
               2, 32'hDEADBEEF, 4'hF, 32'h11000000, 4'h8, 32'h0, 4'h0);
    vt[4] = mk(1, 32'hFFFFFF5A, 2, 32'hA0A1A2A3, 32'hB0B1B2B3, 4'hC,
               2, 32'h5AA0A1A2, 4'hF, 32'hA3B0B100, 4'hE, 32'h0, 4'h0);
    vt[5] = mk(3, 32'h00C0C1C2, 1, 32'hD0D1D2D3, 32'h0, 4'h8,
               1, 32'hC0C1C2D0, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0);
    vt[6] = mk(4, 32'h01020304, 1, 32'hAABBCCDD, 32'h0, 4'hF,
               2, 32'h01020304, 4'hF, 32'hAABBCCDD, 4'hF, 32'h0, 4'h0);

    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.valid_insert = 1'b0; bus.data_insert = '0; bus.keep_insert = '0;
    bus.byte_insert_cnt = '0;
    tick();
    tick();
    do_reset("reset");

    rmode = 0;
    for (int i = 0; i < 7; i++) run_vec(i);

    // Random backpressure over long packets, every header size.
    rmode = 1;
    for (int h = 0; h <= 4; h++) begin
      got_q.delete(); exp_q.delete(); mb.delete();
      hdr = $urandom;
      for (int j = h - 1; j >= 0; j--) mb.push_back(hdr[8*j +: 8]);
      for (int b = 0; b < 64; b++) begin
        pdat[b] = $urandom;
        kb = (b == 63) ? int'($urandom_range(1, 4)) : 4;
        pk[b] = 4'hF << (4 - kb);
        for (int j = 0; j < kb; j++) mb.push_back(pdat[b][8*(3-j) +: 8]);
      end
      build_exp();
      send_header(h, hdr);
      for (int b = 0; b < 64; b++) send_beat(pdat[b], pk[b], b == 63);
      wait_drain(exp_q.size());
      compare_exp($sformatf("rand_h%0d", h));
    end
    rmode = 0;
    repeat (2) tick();

    // Payload waiting ahead of its header, then a back-to-back header.
    got_q.delete(); exp_q.delete();
    bus.valid_in = 1'b1; bus.data_in = 32'h11111111; bus.keep_in = 4'hF; bus.last_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("early_ready_in", 64'(bus.ready_in), 64'd0);
      tick();
    end
    bus.valid_insert = 1'b1; bus.data_insert = 32'hABCDEF77;
    bus.byte_insert_cnt = 3'd1; bus.keep_insert = 4'h1;
    check("hs_cycle_ready_in", 64'(bus.ready_in), 64'd0);
    check("hs_cycle_ready_insert", 64'(bus.ready_insert), 64'd1);
    tick();
    check("post_hdr_ready_in", 64'(bus.ready_in), 64'd1);
    check("stream_ready_insert", 64'(bus.ready_insert), 64'd0);
    tick();
    bus.valid_in = 1'b0; bus.last_in = 1'b0;
    check("flush_ready_insert", 64'(bus.ready_insert), 64'd0);
    check("flush_ready_in", 64'(bus.ready_in), 64'd0);
    tick();
    check("b2b_ready_insert", 64'(bus.ready_insert), 64'd1);
    tick();
    bus.valid_insert = 1'b0;
    send_beat(32'h22222222, 4'hC, 1'b1);
    exp_q.push_back('{d: 32'h77111111, k: 4'hF, l: 1'b0});
    exp_q.push_back('{d: 32'h11000000, k: 4'h8, l: 1'b1});
    exp_q.push_back('{d: 32'h77222200, k: 4'hE, l: 1'b1});
    wait_drain(3);
    compare_exp("early");

    // Reset in the middle of a packet.
    got_q.delete();
    send_header(3, 32'h00112233);
    send_beat(32'h44556677, 4'hF, 1'b0);
    tick();
    do_reset("rst_mid");
    got_q.delete();
    repeat (5) tick();
    check("rst_mid_no_output", 64'(got_q.size()), 64'd0);
    run_vec(0);

    // Reset while the flush beat is pending behind a stalled sink.
    rmode = 2;
    repeat (2) tick();
    send_header(4, 32'hCAFEF00D);
    send_beat(32'h01020304, 4'hF, 1'b1);
    tick();
    check("flush_stall_valid", 64'(bus.valid_out), 64'd1);
    check("flush_stall_ready_in", 64'(bus.ready_in), 64'd0);
    do_reset("rst_flush");
    rmode = 0;
    got_q.delete();
    repeat (5) tick();
    check("rst_flush_no_output", 64'(got_q.size()), 64'd0);
    run_vec(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
